// File: rtl/face_scan_sequencer_pkg.sv
// ============================================================================
// Module   : face_scan_sequencer_pkg
// Purpose  : Shared state encoding and helpers for the cube-face scan sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package face_scan_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DETECT    = 3'd1,
    S_CENTERS   = 3'd2,
    S_COLOR     = 3'd3,
    S_CHECK     = 3'd4,
    S_WAIT_FACE = 3'd5,
    S_HALT      = 3'd6,
    S_ERROR     = 3'd7
  } scan_state_t;

  // DETECT..CHECK are contiguous so a phase index is simply state - S_DETECT
  localparam int NUM_PHASES   = 4;
  localparam int PHASE_IDX_W  = $clog2(NUM_PHASES);

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_phase(input scan_state_t s);
    return (s == S_DETECT) || (s == S_CENTERS) || (s == S_COLOR) || (s == S_CHECK);
  endfunction

  function automatic scan_state_t next_phase(input scan_state_t s);
    case (s)
      S_DETECT:  return S_CENTERS;
      S_CENTERS: return S_COLOR;
      S_COLOR:   return S_CHECK;
      default:   return S_IDLE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/face_scan_sequencer_if.sv
// ============================================================================
// Module   : face_scan_sequencer_if
// Purpose  : Operator controls, phase handshakes and status of the scan sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface face_scan_sequencer_if #(
  parameter int NUM_FACES   = 6,
  parameter int MAX_RETRIES = 3
);
  import face_scan_sequencer_pkg::*;

  localparam int FACE_W  = width_of(NUM_FACES);
  localparam int RETRY_W = width_of(MAX_RETRIES + 1);

  logic               Execute;
  logic               Face;
  logic               ds_done;
  logic               gc_done;
  logic               cs_done;
  logic               cc_done;
  logic               cc_ok;
  logic               ds;
  logic               gc;
  logic               cs;
  logic               cc;
  logic [FACE_W-1:0]  face_idx;
  logic [RETRY_W-1:0] retry_cnt;
  logic               wait_face;
  logic               face_done;
  logic               algstart;
  logic               error;

  modport master (
    output Execute, Face, ds_done, gc_done, cs_done, cc_done, cc_ok,
    input  ds, gc, cs, cc, face_idx, retry_cnt, wait_face, face_done, algstart, error
  );

  modport slave (
    input  Execute, Face, ds_done, gc_done, cs_done, cc_done, cc_ok,
    output ds, gc, cs, cc, face_idx, retry_cnt, wait_face, face_done, algstart, error
  );

endinterface

`default_nettype wire

// File: rtl/face_scan_sequencer_phase_timer.sv
// ============================================================================
// Module   : face_scan_sequencer_phase_timer
// Purpose  : Per-phase wait counter; flags expiry on the last allowed cycle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module face_scan_sequencer_phase_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int               CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      r_count <= '0;
    end else if (run && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == LAST);

endmodule

`default_nettype wire

// File: rtl/face_scan_sequencer.sv
// ============================================================================
// Module   : face_scan_sequencer
// Purpose  : Handshaked scan FSM: detect/centers/color/check per face, then solve
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module face_scan_sequencer #(
  parameter int NUM_FACES      = 6,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  face_scan_sequencer_if.slave   bus
);
  import face_scan_sequencer_pkg::*;

  localparam int                 FACE_W      = width_of(NUM_FACES);
  localparam int                 RETRY_W     = width_of(MAX_RETRIES + 1);
  localparam logic [FACE_W-1:0]  LAST_FACE   = FACE_W'(NUM_FACES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  scan_state_t            r_state;
  scan_state_t            w_state_next;
  logic [FACE_W-1:0]      r_face_idx;
  logic [FACE_W-1:0]      w_face_idx_next;
  logic [RETRY_W-1:0]     r_retry_cnt;
  logic [RETRY_W-1:0]     w_retry_cnt_next;
  logic                   r_face_q;
  logic                   r_face_done;
  logic                   w_face_done_next;
  logic                   w_face_rise;
  logic                   w_in_phase;
  logic                   w_cur_done;
  logic                   w_expired;
  logic                   w_timer_clear;
  logic                   w_timer_run;
  logic [NUM_PHASES-1:0]  w_done_vec;
  logic [PHASE_IDX_W-1:0] w_phase_idx;

  assign w_face_rise = bus.Face & ~r_face_q;
  assign w_in_phase  = is_phase(r_state);
  assign w_done_vec  = {bus.cc_done, bus.cs_done, bus.gc_done, bus.ds_done};
  assign w_phase_idx = PHASE_IDX_W'(3'(r_state) - 3'(S_DETECT));
  // Only the done belonging to the active phase is ever looked at
  assign w_cur_done  = w_in_phase & w_done_vec[w_phase_idx];

  assign w_timer_clear = (w_state_next != r_state);
  assign w_timer_run   = w_in_phase & ~w_cur_done;

  face_scan_sequencer_phase_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_phase_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (w_timer_clear),
    .run     (w_timer_run),
    .expired (w_expired)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_face_idx  <= '0;
      r_retry_cnt <= '0;
      r_face_q    <= 1'b0;
      r_face_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_face_idx  <= w_face_idx_next;
      r_retry_cnt <= w_retry_cnt_next;
      r_face_q    <= bus.Face;
      r_face_done <= w_face_done_next;
    end
  end

  // Abort on Execute low outranks done, timeout and face advance
  always_comb begin
    w_state_next     = r_state;
    w_face_idx_next  = r_face_idx;
    w_retry_cnt_next = r_retry_cnt;
    w_face_done_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Execute) begin
          w_state_next     = S_DETECT;
          w_face_idx_next  = '0;
          w_retry_cnt_next = '0;
        end
      end
      S_DETECT, S_CENTERS, S_COLOR: begin
        if (!bus.Execute) begin
          w_state_next = S_IDLE;
        end else if (w_cur_done) begin
          w_state_next = next_phase(r_state);
        end else if (w_expired) begin
          w_state_next = S_ERROR;
        end
      end
      S_CHECK: begin
        if (!bus.Execute) begin
          w_state_next = S_IDLE;
        end else if (w_cur_done) begin
          if (bus.cc_ok) begin
            w_face_done_next = 1'b1;
            w_state_next     = (r_face_idx == LAST_FACE) ? S_HALT : S_WAIT_FACE;
          end else if (r_retry_cnt == RETRY_LIMIT) begin
            w_state_next = S_ERROR;
          end else begin
            w_retry_cnt_next = r_retry_cnt + 1'b1;
            w_state_next     = S_DETECT;
          end
        end else if (w_expired) begin
          w_state_next = S_ERROR;
        end
      end
      S_WAIT_FACE: begin
        if (!bus.Execute) begin
          w_state_next = S_IDLE;
        end else if (w_face_rise) begin
          w_face_idx_next  = r_face_idx + 1'b1;
          w_retry_cnt_next = '0;
          w_state_next     = S_DETECT;
        end
      end
      S_HALT, S_ERROR: begin
        if (!bus.Execute) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.ds        = (r_state == S_DETECT);
  assign bus.gc        = (r_state == S_CENTERS);
  assign bus.cs        = (r_state == S_COLOR);
  assign bus.cc        = (r_state == S_CHECK);
  assign bus.wait_face = (r_state == S_WAIT_FACE);
  assign bus.algstart  = (r_state == S_HALT);
  assign bus.error     = (r_state == S_ERROR);
  assign bus.face_idx  = r_face_idx;
  assign bus.retry_cnt = r_retry_cnt;
  assign bus.face_done = r_face_done;

endmodule

`default_nettype wire

// File: tb/tb_face_scan_sequencer.sv
// ============================================================================
// Module   : tb_face_scan_sequencer
// Purpose  : Scoreboard bench: stimulus queues expected output vectors, monitor checks changes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_face_scan_sequencer;
  import face_scan_sequencer_pkg::*;

  localparam int NUM_FACES      = 6;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int MAX_RETRIES    = 3;
  localparam int FACE_W         = width_of(NUM_FACES);
  localparam int RETRY_W        = width_of(MAX_RETRIES + 1);
  localparam int VEC_W          = 8 + FACE_W + RETRY_W;

  localparam int P_IDLE = 0, P_DS = 1, P_GC = 2, P_CS = 3, P_CC = 4;
  localparam int P_WF = 5, P_WFD = 6, P_HALT = 7, P_HALTD = 8, P_ERR = 9;

  typedef logic [VEC_W-1:0] vec_t;
  typedef struct {
    vec_t  vec;
    int    prev_len;
    string name;
  } exp_t;

  exp_t exp_q[$];
  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  bit   mon_en    = 1'b0;

  face_scan_sequencer_if #(.NUM_FACES(NUM_FACES), .MAX_RETRIES(MAX_RETRIES)) bus ();

  face_scan_sequencer #(
    .NUM_FACES      (NUM_FACES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic check(input bit ok, input string name, input int act, input int req);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Vector layout: {ds,gc,cs,cc,wait_face,face_done,algstart,error,face_idx,retry_cnt}
  function automatic vec_t mkvec(input int p, input int idx, input int rc);
    logic [7:0] f;
    f = '0;
    case (p)
      P_DS:    f[7] = 1'b1;
      P_GC:    f[6] = 1'b1;
      P_CS:    f[5] = 1'b1;
      P_CC:    f[4] = 1'b1;
      P_WF:    f[3] = 1'b1;
      P_WFD:   begin f[3] = 1'b1; f[2] = 1'b1; end
      P_HALT:  f[1] = 1'b1;
      P_HALTD: begin f[1] = 1'b1; f[2] = 1'b1; end
      P_ERR:   f[0] = 1'b1;
      default: f = '0;
    endcase
    return {f, FACE_W'(idx), RETRY_W'(rc)};
  endfunction

  function automatic vec_t sample();
    return {bus.ds, bus.gc, bus.cs, bus.cc, bus.wait_face, bus.face_done,
            bus.algstart, bus.error, bus.face_idx, bus.retry_cnt};
  endfunction

  task automatic push(input int p, input int idx, input int rc, input int prev_len, input string name);
    exp_t e;
    e.vec      = mkvec(p, idx, rc);
    e.prev_len = prev_len;
    e.name     = name;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  function automatic logic phase_out(input int p);
    case (p)
      P_DS:    return bus.ds;
      P_GC:    return bus.gc;
      P_CS:    return bus.cs;
      default: return bus.cc;
    endcase
  endfunction

  task automatic set_done(input int p, input logic v, input logic ok);
    case (p)
      P_DS:    bus.ds_done = v;
      P_GC:    bus.gc_done = v;
      P_CS:    bus.cs_done = v;
      default: begin bus.cc_done = v; bus.cc_ok = ok; end
    endcase
  endtask

  // Datapath responder: done lands on cycle `delay` of the phase
  task automatic do_phase(input int p, input int delay, input logic ok, input string name);
    int n;
    n = 0;
    while (phase_out(p) !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      check(1'b0, {name, "_enter_timeout"}, 0, 1);
      return;
    end
    repeat (delay - 1) tick();
    set_done(p, 1'b1, ok);
    tick();
    set_done(p, 1'b0, 1'b0);
  endtask

  task automatic run_face(input int f, input int nfail);
    int rc;
    rc = 0;
    for (int a = 0; a <= nfail; a++) begin
      push(P_GC, f, rc, 2, "gc_enter");
      do_phase(P_DS, 2, 1'b0, "ds");
      push(P_CS, f, rc, 2, "cs_enter");
      do_phase(P_GC, 2, 1'b0, "gc");
      push(P_CC, f, rc, 2, "cc_enter");
      do_phase(P_CS, 2, 1'b0, "cs");
      if (a < nfail) begin
        if (rc == MAX_RETRIES) push(P_ERR, f, rc, 2, "retry_exhausted");
        else                   push(P_DS, f, rc + 1, 2, "retry_ds");
        do_phase(P_CC, 2, 1'b0, "cc");
        if (rc == MAX_RETRIES) return;
        rc++;
      end else begin
        if (f == NUM_FACES - 1) begin
          push(P_HALTD, f, rc, 2, "halt_face_done");
          push(P_HALT, f, rc, 1, "halt");
        end else begin
          push(P_WFD, f, rc, 2, "face_done");
          push(P_WF, f, rc, 1, "wait_face");
        end
        do_phase(P_CC, 2, 1'b1, "cc");
      end
    end
  endtask

  task automatic press_face(input int f);
    tick();
    push(P_DS, f, 0, 1, "advance_ds");
    bus.Face = 1'b1;
    tick();
    bus.Face = 1'b0;
  endtask

  task automatic end_run(input int idx, input int rc, input int settle, input int prev_len);
    repeat (settle) tick();
    push(P_IDLE, idx, rc, prev_len, "idle_after_release");
    bus.Execute = 1'b0;
    tick();
  endtask

  task automatic start_run();
    push(P_DS, 0, 0, 0, "start_ds");
    bus.Execute = 1'b1;
  endtask

  initial begin : monitor
    vec_t prev;
    vec_t cur;
    int   run;
    bit   first;
    exp_t e;
    first = 1'b1;
    run   = 0;
    prev  = '0;
    forever begin
      @(negedge Clk);
      if (mon_en) begin
        cur = sample();
        if (first || cur !== prev) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_change", int'(cur), int'(prev));
          end else begin
            e = exp_q.pop_front();
            check(cur === e.vec, e.name, int'(cur), int'(e.vec));
            if (!first && e.prev_len > 0)
              check(run == e.prev_len, {e.name, "_prev_len"}, run, e.prev_len);
          end
          prev  = cur;
          run   = 1;
          first = 1'b0;
        end else begin
          run++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within 20000 cycles");
    $fatal(1);
  end

  initial begin : stimulus
    bus.Execute = 1'b0;
    bus.Face    = 1'b0;
    bus.ds_done = 1'b0;
    bus.gc_done = 1'b0;
    bus.cs_done = 1'b0;
    bus.cc_done = 1'b0;
    bus.cc_ok   = 1'b0;
    repeat (3) @(posedge Clk);
    tick();
    Reset = 1'b0;
    push(P_IDLE, 0, 0, 0, "reset_state");
    @(posedge Clk);
    #1 mon_en = 1'b1;
    tick();

    // Six faces, face 2 fails its check twice before passing
    start_run();
    for (int f = 0; f < NUM_FACES; f++) begin
      if (f > 0) press_face(f);
      run_face(f, (f == 2) ? 2 : 0);
    end
    end_run(NUM_FACES - 1, 0, 2, 2);

    // Four failed checks on face 0 exhaust the retries
    tick();
    start_run();
    run_face(0, MAX_RETRIES + 1);
    end_run(0, MAX_RETRIES, 2, 3);

    // CENTERS never completes
    tick();
    start_run();
    push(P_GC, 0, 0, 2, "gc_enter");
    do_phase(P_DS, 2, 1'b0, "ds");
    push(P_ERR, 0, 0, TIMEOUT_CYCLES, "timeout_error");
    repeat (TIMEOUT_CYCLES) tick();
    end_run(0, 0, 2, 3);

    // gc_done on the final allowed cycle, then abort in COLOR racing cs_done
    tick();
    start_run();
    push(P_GC, 0, 0, 2, "gc_enter");
    do_phase(P_DS, 2, 1'b0, "ds");
    push(P_CS, 0, 0, TIMEOUT_CYCLES, "late_gc_to_color");
    do_phase(P_GC, TIMEOUT_CYCLES, 1'b0, "gc_late");
    push(P_IDLE, 0, 0, 2, "abort_in_color");
    tick();
    bus.cs_done = 1'b1;
    bus.Execute = 1'b0;
    tick();
    bus.cs_done = 1'b0;

    // Face held across CHECK into WAIT_FACE must not advance; stray dones ignored
    tick();
    start_run();
    push(P_GC, 0, 0, 2, "gc_enter");
    do_phase(P_DS, 2, 1'b0, "ds");
    push(P_CS, 0, 0, 2, "cs_enter");
    do_phase(P_GC, 2, 1'b0, "gc");
    push(P_CC, 0, 0, 2, "cc_enter");
    do_phase(P_CS, 2, 1'b0, "cs");
    bus.Face = 1'b1;
    push(P_WFD, 0, 0, 2, "face_done_held");
    push(P_WF, 0, 0, 1, "wait_face_held");
    do_phase(P_CC, 2, 1'b1, "cc");
    tick();
    bus.ds_done = 1'b1;
    bus.gc_done = 1'b1;
    tick();
    bus.ds_done = 1'b0;
    bus.gc_done = 1'b0;
    repeat (3) tick();
    bus.Face = 1'b0;
    repeat (2) tick();
    push(P_DS, 1, 0, 0, "repress_advance");
    bus.Face = 1'b1;
    tick();
    bus.Face = 1'b0;
    run_face(1, 0);

    // Reset while waiting for the operator, then abort straight out of DETECT
    tick();
    push(P_IDLE, 0, 0, 0, "reset_in_wait_face");
    Reset = 1'b1;
    tick();
    push(P_DS, 0, 0, 1, "restart_after_reset");
    Reset = 1'b0;
    tick();
    push(P_IDLE, 0, 0, 1, "abort_in_detect");
    bus.Execute = 1'b0;
    tick();

    repeat (5) tick();
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/face_scan_sequencer.md
Name: face_scan_sequencer

Overview:
Parametrised control FSM sequencing the cube-face scan pipeline: detect start, get centers, color detection/store, color check. Repeats for NUM_FACES faces, waiting for an operator Face press between faces, then raises algstart for the solver. Unlike fixed one-cycle phase stepping, each phase waits for a done handshake from its datapath, with a per-phase timeout, bounded retry on color-check failure, and abort on Execute release.

Parameters:
NUM_FACES, 6, faces scanned per run (>=1)
TIMEOUT_CYCLES, 1024, max cycles any phase may wait for its done (>=2)
MAX_RETRIES, 3, re-scans of one face allowed after cc_ok=0 before error
FACE_W, $clog2(NUM_FACES) min 1, derived width of face_idx
RETRY_W, $clog2(MAX_RETRIES+1) min 1, derived width of retry_cnt

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Execute  in  1  level; high starts/holds a run, low aborts or returns to idle
Face  in  1  operator advance button, level; rising edge detected internally
ds_done  in  1  detect-start phase complete
gc_done  in  1  get-centers phase complete
cs_done  in  1  color detection/store complete
cc_done  in  1  color check complete
cc_ok  in  1  color check result, qualified by cc_done
ds  out  1  high throughout DETECT
gc  out  1  high throughout CENTERS
cs  out  1  high throughout COLOR
cc  out  1  high throughout CHECK
face_idx  out  FACE_W  face currently being scanned, 0..NUM_FACES-1
retry_cnt  out  RETRY_W  retries used on current face
wait_face  out  1  high in WAIT_FACE
face_done  out  1  one-cycle pulse when a face passes check
algstart  out  1  high throughout HALT
error  out  1  high throughout ERROR

Behaviour:
- Reset (sync, priority over all): state=IDLE, face_idx=0, retry_cnt=0, timer=0, face_q=0, face_done=0; all outputs 0.
- Moore outputs decoded from state register; face_done registered. Transition at edge N means output change visible after edge N.
- States: IDLE, DETECT, CENTERS, COLOR, CHECK, WAIT_FACE, HALT, ERROR.
- IDLE: Execute=1 -> DETECT; face_idx<=0, retry_cnt<=0.
- DETECT/CENTERS/COLOR: respective done=1 -> next phase (DETECT->CENTERS->COLOR->CHECK).
- CHECK: cc_done&cc_ok -> face_done pulse; if face_idx==NUM_FACES-1 -> HALT else WAIT_FACE. cc_done&!cc_ok -> if retry_cnt==MAX_RETRIES -> ERROR, else retry_cnt++ and -> DETECT (same face_idx).
- WAIT_FACE: face_rise (Face & ~face_q) -> face_idx++, retry_cnt<=0, -> DETECT. Face held high since before entry produces no rise; must be released and re-pressed.
- HALT: algstart=1; Execute=0 -> IDLE. ERROR: error=1; Execute=0 -> IDLE. Neither honours Face or done inputs.
- Timeout: timer clears on every state change; increments each cycle in DETECT/CENTERS/COLOR/CHECK without done; when timer==TIMEOUT_CYCLES-1 and no done -> ERROR. Done in that same cycle wins.
- Abort: Execute=0 in any phase state or WAIT_FACE -> IDLE next edge; abort has priority over done, timeout and face_rise. face_idx/retry_cnt hold until next start.
- Done inputs outside their phase are ignored. face_q samples Face every cycle.
- NUM_FACES=1: CHECK pass goes straight to HALT, WAIT_FACE never entered.

Decomposition:
- Package scan_pkg: typedef enum scan_state_t (8 states, explicit 3-bit encoding), localparams for phase count.
- Sub-module phase_timer (param TIMEOUT_CYCLES): inputs Clk, Reset, clear, run; output expired. Edge detect stays inline.

Test Plan:
- Happy path, NUM_FACES=6, done inputs 2 cycles after each phase entry, cc_ok=1, Face pulsed in WAIT_FACE -> six ds/gc/cs/cc sequences, face_idx 0..5, 6 face_done pulses, algstart=1; Execute=0 -> IDLE next edge.
- Retry, MAX_RETRIES=3: face 2 returns cc_ok=0 twice then 1 -> retry_cnt 1,2 then 0 after advance, face_idx stays 2 across retries, error=0.
- Retry exhaustion: cc_ok=0 four times on face 0 -> ERROR after 4th check, error=1, algstart=0; Execute=0 -> IDLE.
- Timeout, TIMEOUT_CYCLES=16: gc_done never asserted -> ERROR exactly 16 cycles after CENTERS entry; gc_done in the 16th cycle -> COLOR, not ERROR.
- Face held high through CHECK into WAIT_FACE -> no advance; release then press -> DETECT with face_idx+1.
- Abort: Execute dropped in COLOR same cycle as cs_done -> IDLE, cs=0 next cycle; Reset asserted in WAIT_FACE -> all outputs 0, face_idx=0.
